spi_master_multi: RTL and testbench
===================================

// Module: spi_master_multi
// PURPOSE
// - Parametrised SPI master behind Z80 I/O ports; successor of the single-card SD port logic.
// - Adds N chip selects, a programmable SCK divider, a status port and a clean busy/done FSM.
// - Sits beside the CPU bus decoder; its d_out is muxed onto the CPU data bus and spi_wait feeds the wait generator.
// PARAMETERS
// - CS_COUNT    2      number of active-low chip-select outputs (1..8)
// - DIV_WIDTH   4      width of the SCK divider field
// - DIV_RESET   0      divider value after reset; SCK half-period = (div+1) clk28 cycles
// - PORT_DATA   8'hEB  data port address (bus.a[7:0])
// - PORT_CS     8'hE7  chip-select port address
// - PORT_CTRL   8'hEF  divider/status port address
// PORTS
// - clk28         in   1           system clock, 28 MHz
// - rst_n         in   1           asynchronous active-low reset
// - en            in   1           block enable; when 0, no port decodes and no transfer starts
// - bus           in   cpu_bus     CPU bus interface (a, d, rd, wr, ioreq)
// - d_out         out  8           read data to the CPU bus mux
// - d_out_active  out  1           d_out is valid and must drive the bus
// - spi_sck       out  1           SPI clock, mode 0, idle low
// - spi_mosi      out  1           SPI data out, MSB first, idle high
// - spi_miso      in   1           SPI data in
// - spi_cs        out  CS_COUNT    chip selects, active low
// - spi_wait      out  1           transfer in progress; CPU wait request
// BEHAVIOUR
// - Reset: spi_cs all 1; spi_sck 0; spi_mosi 1; rx register 8'hFF; divider DIV_RESET; FSM IDLE; spi_wait 0; d_out_active 0.
// - Reset mid-transfer aborts immediately. No partial byte is retained.
// - Access detection: an access is en && ioreq && (rd|wr) && address match. Only the rising edge of that condition, compared against a one-cycle registered copy, counts. A held rd or wr therefore starts at most one transfer.
// - PORT_CS write: spi_cs[i] <= d[i] for i < CS_COUNT; other bits are ignored. The write applies the next cycle, even mid-transfer.
// - PORT_CTRL write: div <= d[DIV_WIDTH-1:0].
// - PORT_CTRL read: d_out = {busy, 7'b0}.
// - PORT_DATA write in IDLE: tx <= d and the transfer starts. A PORT_DATA write while busy is ignored, with no restart.
// - PORT_DATA read: d_out = rx register, whether busy or not.
// - d_out_active is registered: high the cycle after a matching rd is seen, and held while rd and the match persist.
// - FSM states:
//   - IDLE -> LEAD on start. Latches div into a half-period counter. spi_mosi = tx[7]. spi_wait rises the cycle after the access edge.
//   - LEAD: SCK low for div+1 cycles, then SCK goes high and miso is sampled into the shift register. Go to TRAIL.
//   - TRAIL: SCK high for div+1 cycles, then SCK goes low and mosi takes the next bit. After bit 7, go to DONE; otherwise go to LEAD.
//   - DONE: one cycle. rx <= shift register, spi_wait falls, spi_mosi returns to 1. Go to IDLE.
// - Latency: write edge to spi_wait falling = 1 + 16*(div+1) + 1 clk28 cycles.
// - A divider write during a transfer affects only the next transfer. The counter wraps at div; div = 0 gives SCK = clk28/2.
// - en falling mid-transfer does not abort; the byte completes.
// CONFIGURATION
// - SPI_PREFETCH_EN defined: a PORT_DATA read in IDLE returns the current rx and also starts a transfer with tx = 8'hFF. This allows back-to-back block reads with no dummy writes.
// - SPI_PREFETCH_EN undefined: a PORT_DATA read never starts a transfer; only writes do.
// STRUCTURE
// - Package spi_master_pkg: FSM state enum (IDLE, LEAD, TRAIL, DONE) and default port address localparams.
// - Sub-module spi_shift_engine: divider counter, bit counter, shift register and the FSM.
// - The top level keeps port decoding, the cs/div registers and the read mux.
// TESTING
// - Write 8'hA5 to PORT_DATA with div = 0 and a MISO loopback -> 8 SCK pulses, MOSI bits 1,0,1,0,0,1,0,1. spi_wait high for 17 cycles after the access edge. A PORT_DATA read then returns 8'hA5.
// - Write div = 3, then 8'h00 -> SCK half-period of 4 cycles; spi_wait high for 65 cycles. A second write issued mid-transfer is ignored: still 8 SCK pulses, and tx is unchanged.
// - Write 8'b10 to PORT_CS with CS_COUNT = 2 -> spi_cs = 2'b10. Write 8'hFF -> spi_cs = 2'b11, upper bits ignored.
// - Hold rd on PORT_DATA for 40 cycles with SPI_PREFETCH_EN -> exactly one transfer of 8'hFF starts; d_out_active high throughout. Without the macro -> no SCK activity.
// - Assert rst_n low after the 3rd SCK edge -> spi_sck 0, spi_mosi 1, spi_cs all 1, spi_wait 0, rx = 8'hFF, divider = DIV_RESET.
// - With en = 0, access all three ports -> no state change and d_out_active stays 0.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared definitions for the multi-chip-select SPI master: FSM state
// encoding and the default Z80 I/O port addresses.
package spi_master_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        TRAIL = 2'd2,
        DONE  = 2'd3
    } spi_state_t;

    localparam logic [7:0] PORT_DATA_DEF = 8'hEB;
    localparam logic [7:0] PORT_CS_DEF   = 8'hE7;
    localparam logic [7:0] PORT_CTRL_DEF = 8'hEF;

endpackage

// File: rtl/spi_master_multi_if.sv
// CPU-side I/O bus seen by the SPI master. Strobes are active high here;
// the bus decoder in front of this block has already inverted the Z80 pins.
interface cpu_bus;
    logic [15:0] a;
    logic [7:0]  d;
    logic        rd;
    logic        wr;
    logic        ioreq;

    modport master (output a, d, rd, wr, ioreq);
    modport slave  (input  a, d, rd, wr, ioreq);
endinterface

// File: rtl/spi_shift_engine.sv
// Bit engine of the SPI master: half-period divider, bit counter, shift
// register and the IDLE/LEAD/TRAIL/DONE sequencer. Mode 0, MSB first.
import spi_master_pkg::*;

module spi_shift_engine #(
    parameter int DIV_WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [7:0]           i_tx,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic                 i_miso,
    output logic                 o_sck,
    output logic                 o_mosi,
    output logic                 o_busy,
    output logic [7:0]           o_rx
);

    spi_state_t           r_state;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_div_lat;
    logic [2:0]           r_bit;
    logic [7:0]           r_shift;
    logic                 r_sck;
    logic                 r_mosi;
    logic                 r_busy;
    logic [7:0]           r_rx;

    // Sequencer: each SCK phase lasts div+1 cycles; MISO enters on the rising
    // edge and the next MOSI bit leaves on the falling edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_div_lat <= '0;
            r_bit     <= '0;
            r_shift   <= 8'hFF;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b1;
            r_busy    <= 1'b0;
            r_rx      <= 8'hFF;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state   <= LEAD;
                        r_cnt     <= i_div;
                        r_div_lat <= i_div;
                        r_bit     <= '0;
                        r_shift   <= i_tx;
                        r_mosi    <= i_tx[7];
                        r_busy    <= 1'b1;
                    end
                end
                LEAD: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= r_div_lat;
                        r_sck   <= 1'b1;
                        r_shift <= {r_shift[6:0], i_miso};
                        r_state <= TRAIL;
                    end else begin
                        r_cnt <= r_cnt - DIV_WIDTH'(1);
                    end
                end
                TRAIL: begin
                    if (r_cnt == '0) begin
                        r_cnt <= r_div_lat;
                        r_sck <= 1'b0;
                        if (r_bit == 3'd7) begin
                            r_state <= DONE;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_mosi  <= r_shift[7];
                            r_state <= LEAD;
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_WIDTH'(1);
                    end
                end
                DONE: begin
                    r_rx    <= r_shift;
                    r_busy  <= 1'b0;
                    r_mosi  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_sck  = r_sck;
    assign o_mosi = r_mosi;
    assign o_busy = r_busy;
    assign o_rx   = r_rx;

endmodule

// File: rtl/spi_master_multi.sv
// SPI master behind three Z80 I/O ports (data, chip select, divider/status).
// Optional feature macro: SPI_PREFETCH_EN -- a data-port read while idle also
// launches a transfer of 8'hFF so block reads need no dummy writes.
import spi_master_pkg::*;

module spi_master_multi #(
    parameter int         CS_COUNT  = 2,
    parameter int         DIV_WIDTH = 4,
    parameter int         DIV_RESET = 0,
    parameter logic [7:0] PORT_DATA = PORT_DATA_DEF,
    parameter logic [7:0] PORT_CS   = PORT_CS_DEF,
    parameter logic [7:0] PORT_CTRL = PORT_CTRL_DEF
) (
    input  logic                clk28,
    input  logic                rst_n,
    input  logic                en,
    cpu_bus.slave               bus,
    output logic [7:0]          d_out,
    output logic                d_out_active,
    output logic                spi_sck,
    output logic                spi_mosi,
    input  logic                spi_miso,
    output logic [CS_COUNT-1:0] spi_cs,
    output logic                spi_wait
);

    logic                 w_hit_data, w_hit_cs, w_hit_ctrl;
    logic                 w_sel, w_acc, w_edge, w_wr_edge, w_rd_edge;
    logic                 w_start, w_busy;
    logic [7:0]           w_tx, w_rx;
    logic                 w_unused_hi;

    logic                 r_acc_d;
    logic [CS_COUNT-1:0]  r_cs;
    logic [DIV_WIDTH-1:0] r_div;
    logic [7:0]           r_dout;
    logic                 r_dact;

    // Only the low address byte decodes, as on the original SD port.
    assign w_unused_hi = ^bus.a[15:8];
    assign w_hit_data  = (bus.a[7:0] == PORT_DATA);
    assign w_hit_cs    = (bus.a[7:0] == PORT_CS);
    assign w_hit_ctrl  = (bus.a[7:0] == PORT_CTRL);

    // A held strobe must not retrigger, so act only on the access edge.
    assign w_sel     = en && bus.ioreq;
    assign w_acc     = w_sel && (bus.rd || bus.wr) && (w_hit_data || w_hit_cs || w_hit_ctrl);
    assign w_edge    = w_acc && !r_acc_d;
    assign w_wr_edge = w_edge && bus.wr;
    assign w_rd_edge = w_edge && bus.rd && !bus.wr;

`ifdef SPI_PREFETCH_EN
    assign w_start = w_hit_data && !w_busy && (w_wr_edge || w_rd_edge);
    assign w_tx    = bus.wr ? bus.d : 8'hFF;
`else
    assign w_start = w_hit_data && !w_busy && w_wr_edge;
    assign w_tx    = bus.d;
`endif

    spi_shift_engine #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_engine (
        .i_clk   (clk28),
        .i_rst_n (rst_n),
        .i_start (w_start),
        .i_tx    (w_tx),
        .i_div   (r_div),
        .i_miso  (spi_miso),
        .o_sck   (spi_sck),
        .o_mosi  (spi_mosi),
        .o_busy  (w_busy),
        .o_rx    (w_rx)
    );

    // Edge history, chip-select and divider registers, registered read path.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_d <= 1'b0;
            r_cs    <= '1;
            r_div   <= DIV_WIDTH'(DIV_RESET);
            r_dout  <= 8'hFF;
            r_dact  <= 1'b0;
        end else begin
            r_acc_d <= w_acc;
            r_dact  <= w_sel && bus.rd && (w_hit_data || w_hit_ctrl);
            if (w_wr_edge && w_hit_cs)
                r_cs <= bus.d[CS_COUNT-1:0];
            if (w_wr_edge && w_hit_ctrl)
                r_div <= bus.d[DIV_WIDTH-1:0];
            if (w_rd_edge && w_hit_data)
                r_dout <= w_rx;
            else if (w_rd_edge && w_hit_ctrl)
                r_dout <= {w_busy, 7'b0};
        end
    end

    assign spi_cs       = r_cs;
    assign spi_wait     = w_busy;
    assign d_out        = r_dout;
    assign d_out_active = r_dact;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi with MOSI looped back to MISO.
// Honours SPI_PREFETCH_EN in the held-read expectations.
module tb_spi_master_multi;
    import spi_master_pkg::*;

    logic       clk28 = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b1;
    logic [7:0] d_out;
    logic       d_out_active;
    logic       spi_sck, spi_mosi, spi_miso, spi_wait;
    logic [1:0] spi_cs;

    int total = 0;
    int bad   = 0;

    cpu_bus bus_if ();

    spi_master_multi dut (
        .clk28        (clk28),
        .rst_n        (rst_n),
        .en           (en),
        .bus          (bus_if),
        .d_out        (d_out),
        .d_out_active (d_out_active),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_cs       (spi_cs),
        .spi_wait     (spi_wait)
    );

    always #18 clk28 = ~clk28;
    assign spi_miso = spi_mosi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus_if.a = 16'h0000; bus_if.d = 8'h00;
        bus_if.rd = 1'b0; bus_if.wr = 1'b0; bus_if.ioreq = 1'b0;
    endtask

    task automatic drive(input logic [7:0] addr, input logic [7:0] data, input logic is_wr);
        bus_if.a = {8'h12, addr}; bus_if.d = data;
        bus_if.wr = is_wr; bus_if.rd = !is_wr; bus_if.ioreq = 1'b1;
    endtask

    task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
        drive(addr, data, 1'b1);
        @(posedge clk28); @(negedge clk28);
        bus_idle();
        @(negedge clk28);
    endtask

    task automatic io_read(input logic [7:0] addr, output logic [7:0] data, output logic act);
        drive(addr, 8'h00, 1'b0);
        @(posedge clk28); @(negedge clk28);
        data = d_out; act = d_out_active;
        bus_idle();
        @(negedge clk28);
    endtask

    // Data-port write, then watch the whole transfer from the next negedge.
    task automatic xfer(input logic [7:0] data, input int inject_at,
                        output int wcyc, output int pulses, output logic [7:0] bits);
        logic prev;
        wcyc = 0; pulses = 0; bits = 8'h00; prev = 1'b0;
        drive(PORT_DATA_DEF, data, 1'b1);
        @(posedge clk28); @(negedge clk28);
        bus_idle();
        for (int i = 0; i < 400; i++) begin
            if (!spi_wait) break;
            wcyc++;
            if (spi_sck && !prev) begin
                pulses++;
                bits = {bits[6:0], spi_mosi};
            end
            prev = spi_sck;
            if (i == inject_at) drive(PORT_DATA_DEF, 8'h5A, 1'b1);
            else if (i == inject_at + 1) bus_idle();
            @(negedge clk28);
        end
        bus_idle();
        @(negedge clk28);
    endtask

    initial begin
        logic [7:0] rd;
        logic       act;
        logic       prev;
        logic [7:0] held_dout;
        int         wcyc, pulses, act_low, tog;
        logic [7:0] bits;

        bus_idle();
        repeat (3) @(negedge clk28);
        chk("rst_cs", 32'(spi_cs), 32'h3);
        chk("rst_sck", 32'(spi_sck), 32'h0);
        chk("rst_mosi", 32'(spi_mosi), 32'h1);
        chk("rst_wait", 32'(spi_wait), 32'h0);
        chk("rst_dact", 32'(d_out_active), 32'h0);
        rst_n = 1'b1;
        @(negedge clk28);

        io_read(PORT_DATA_DEF, rd, act);
        chk("rx_after_rst", 32'(rd), 32'hFF);
        chk("rx_after_rst_act", 32'(act), 32'h1);
        io_read(PORT_CTRL_DEF, rd, act);
        chk("status_idle", 32'(rd), 32'h00);

        // div = 0 (reset value), byte A5 looped back.
        xfer(8'hA5, -1, wcyc, pulses, bits);
        chk("a5_wait_cycles", 32'(wcyc), 32'd17);
        chk("a5_pulses", 32'(pulses), 32'd8);
        chk("a5_mosi_bits", 32'(bits), 32'hA5);
        io_read(PORT_DATA_DEF, rd, act);
        chk("a5_rx", 32'(rd), 32'hA5);

        // div = 3, byte 00, with an ignored write mid-transfer.
        io_write(PORT_CTRL_DEF, 8'h03);
        xfer(8'h00, 10, wcyc, pulses, bits);
        chk("d3_wait_cycles", 32'(wcyc), 32'd65);
        chk("d3_pulses", 32'(pulses), 32'd8);
        chk("d3_mosi_bits", 32'(bits), 32'h00);
        io_read(PORT_DATA_DEF, rd, act);
        chk("d3_rx", 32'(rd), 32'h00);

        io_write(PORT_CS_DEF, 8'h02);
        chk("cs_10", 32'(spi_cs), 32'h2);
        io_write(PORT_CS_DEF, 8'hFF);
        chk("cs_ff", 32'(spi_cs), 32'h3);

        // Held data-port read for 40 cycles at div = 0.
        io_write(PORT_CTRL_DEF, 8'h00);
        act_low = 0; pulses = 0; prev = 1'b0; held_dout = 8'h00;
        drive(PORT_DATA_DEF, 8'h00, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk28);
            if (i == 0) held_dout = d_out;
            if (!d_out_active) act_low++;
            if (spi_sck && !prev) pulses++;
            prev = spi_sck;
        end
        bus_idle();
        repeat (20) begin
            @(negedge clk28);
            if (spi_sck && !prev) pulses++;
            prev = spi_sck;
        end
        chk("held_act_low_cycles", 32'(act_low), 32'd0);
        chk("held_dout", 32'(held_dout), 32'h00);
        io_read(PORT_DATA_DEF, rd, act);
`ifdef SPI_PREFETCH_EN
        chk("held_pulses", 32'(pulses), 32'd8);
        chk("held_rx", 32'(rd), 32'hFF);
`else
        chk("held_pulses", 32'(pulses), 32'd0);
        chk("held_rx", 32'(rd), 32'h00);
`endif
        repeat (25) @(negedge clk28);

        // div = 2 transfer, then a transfer aborted by reset.
        io_write(PORT_CTRL_DEF, 8'h02);
        xfer(8'h3C, -1, wcyc, pulses, bits);
        chk("d2_wait_cycles", 32'(wcyc), 32'd49);
        chk("d2_mosi_bits", 32'(bits), 32'h3C);
        io_read(PORT_DATA_DEF, rd, act);
        chk("d2_rx", 32'(rd), 32'h3C);
        io_write(PORT_CS_DEF, 8'h00);
        chk("cs_00", 32'(spi_cs), 32'h0);
        drive(PORT_DATA_DEF, 8'hC3, 1'b1);
        @(posedge clk28); @(negedge clk28);
        bus_idle();
        tog = 0; prev = spi_sck;
        for (int i = 0; i < 200; i++) begin
            if (spi_sck != prev) tog++;
            prev = spi_sck;
            if (tog == 3) break;
            @(negedge clk28);
        end
        chk("abort_edges_seen", 32'(tog), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("abort_sck", 32'(spi_sck), 32'h0);
        chk("abort_mosi", 32'(spi_mosi), 32'h1);
        chk("abort_cs", 32'(spi_cs), 32'h3);
        chk("abort_wait", 32'(spi_wait), 32'h0);
        @(negedge clk28);
        rst_n = 1'b1;
        @(negedge clk28);
        io_read(PORT_DATA_DEF, rd, act);
        chk("abort_rx", 32'(rd), 32'hFF);
        xfer(8'h81, -1, wcyc, pulses, bits);
        chk("abort_div_reset_cycles", 32'(wcyc), 32'd17);
        chk("abort_81_bits", 32'(bits), 32'h81);

        // Block disabled: nothing decodes.
        en = 1'b0;
        io_write(PORT_CS_DEF, 8'h00);
        io_write(PORT_CTRL_DEF, 8'h05);
        io_write(PORT_DATA_DEF, 8'h12);
        chk("en0_wait", 32'(spi_wait), 32'h0);
        chk("en0_sck", 32'(spi_sck), 32'h0);
        chk("en0_cs", 32'(spi_cs), 32'h3);
        io_read(PORT_DATA_DEF, rd, act);
        chk("en0_data_act", 32'(act), 32'h0);
        io_read(PORT_CTRL_DEF, rd, act);
        chk("en0_ctrl_act", 32'(act), 32'h0);
        en = 1'b1;
        @(negedge clk28);
        xfer(8'hC3, -1, wcyc, pulses, bits);
        chk("en1_wait_cycles", 32'(wcyc), 32'd17);
        chk("en1_bits", 32'(bits), 32'hC3);
        io_read(PORT_DATA_DEF, rd, act);
        chk("en1_rx", 32'(rd), 32'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
